seven_seg_scan_driver: RTL and testbench

Memory-mapped four-digit hex display peripheral that sits on the processor bus in place of the single-command seven-segment path and drives the board's multiplexed common-anode display. It captures four nibbles and a control byte from bus writes, then time-multiplexes the digits with a programmable refresh divider. Hex decoding, per-digit decimal points and optional leading-zero blanking are handled internally, so software writes values, not segment patterns.

---
 rtl/seven_seg_scan_driver_if.sv | 27 ++
 rtl/seven_seg_scan_driver.sv | 116 +++++++++++
 tb/tb_seven_seg_scan_driver.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_driver_if.sv
// Bus write port and display pins of the four-digit seven-segment scanner.
// Latency: none, this only groups wires.
// Backpressure: none, writes are fire-and-forget single-cycle strobes.
//
// Signals (named from the peripheral's point of view):
//   i_bus_we   : write strobe, sampled on the rising clock edge
//   i_bus_addr : byte address of the write
//   i_bus_data : write data
//   o_sel      : digit anodes, active-low, bit 0 = rightmost digit
//   o_digit    : cathodes, active-low, {dp,g,f,e,d,c,b,a}
interface seven_seg_scan_driver_if;
   logic       i_bus_we;
   logic [7:0] i_bus_addr;
   logic [7:0] i_bus_data;
   logic [3:0] o_sel;
   logic [7:0] o_digit;

   modport master (
      output i_bus_we, i_bus_addr, i_bus_data,
      input  o_sel, o_digit
   );

   modport slave (
      input  i_bus_we, i_bus_addr, i_bus_data,
      output o_sel, o_digit
   );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Four-digit hex seven-segment scanner: bus-written digits/control, time-multiplexed common-anode drive.
// Latency: one cycle from register/index state to SEL/DIGIT (both outputs registered).
// Backpressure: none; every matching write is accepted on the edge it is presented.
//
// Ports:
//   i_clk : system clock, all logic on the rising edge
//   i_rst : asynchronous active-high reset, forces SEL=4'b1111 / DIGIT=8'hFF at once
//   bus   : slave side of seven_seg_scan_driver_if (write strobe/address/data in, SEL/DIGIT out)
// Register map (write-only): BASE+0..3 digit 0..3 value (data[3:0]),
//   BASE+4 control: bit0 enable, bits[7:4] per-digit decimal point.
// Optional feature: define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank leading zeros on digits 3..1.
module seven_seg_scan_driver #(
   parameter logic [7:0] BASE_ADDR   = 8'hD0,
   parameter int         REFRESH_DIV = 50000
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   seven_seg_scan_driver_if.slave  bus
);

   localparam int             CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0]  TC = CW'(REFRESH_DIV - 1);

   logic [3:0][3:0] r_digit;
   logic            r_en;
   logic [3:0]      r_dp;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_idx;
   logic [3:0]      r_sel;
   logic [7:0]      r_seg;

   logic [7:0]      w_off;
   logic            w_wr_dig;
   logic            w_wr_ctl;
   logic [3:0]      w_blank;
   logic [6:0]      w_seg_nxt;

   // Active-low segments {g,f,e,d,c,b,a}; dp is added separately.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      case (v)
         4'h0:    hex_to_seg = 7'h40;
         4'h1:    hex_to_seg = 7'h79;
         4'h2:    hex_to_seg = 7'h24;
         4'h3:    hex_to_seg = 7'h30;
         4'h4:    hex_to_seg = 7'h19;
         4'h5:    hex_to_seg = 7'h12;
         4'h6:    hex_to_seg = 7'h02;
         4'h7:    hex_to_seg = 7'h78;
         4'h8:    hex_to_seg = 7'h00;
         4'h9:    hex_to_seg = 7'h10;
         4'hA:    hex_to_seg = 7'h08;
         4'hB:    hex_to_seg = 7'h03;
         4'hC:    hex_to_seg = 7'h46;
         4'hD:    hex_to_seg = 7'h21;
         4'hE:    hex_to_seg = 7'h06;
         default: hex_to_seg = 7'h0E;
      endcase
   endfunction

   // Offset arithmetic wraps in 8 bits, so addresses below BASE land far above 4.
   assign w_off    = bus.i_bus_addr - BASE_ADDR;
   assign w_wr_dig = bus.i_bus_we && (w_off < 8'd4);
   assign w_wr_ctl = bus.i_bus_we && (w_off == 8'd4);

   always_comb begin
      w_blank = 4'b0000;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      // A digit is blank only if it and every digit to its left are zero.
      w_blank[3] = (r_digit[3] == 4'h0);
      w_blank[2] = w_blank[3] && (r_digit[2] == 4'h0);
      w_blank[1] = w_blank[2] && (r_digit[1] == 4'h0);
`endif
      w_seg_nxt = w_blank[r_idx] ? 7'h7F : hex_to_seg(r_digit[r_idx]);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_digit <= '0;
         r_en    <= 1'b1;
         r_dp    <= 4'h0;
         r_cnt   <= '0;
         r_idx   <= 2'd0;
         r_sel   <= 4'b1111;
         r_seg   <= 8'hFF;
      end else begin
         if (w_wr_dig) begin
            r_digit[w_off[1:0]] <= bus.i_bus_data[3:0];
         end
         if (w_wr_ctl) begin
            r_en <= bus.i_bus_data[0];
            r_dp <= bus.i_bus_data[7:4];
         end

         // Scan keeps running while disabled so re-enabling stays in phase.
         if (r_cnt == TC) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end

         // Outputs use pre-edge state, giving the single-cycle latency.
         if (r_en) begin
            r_sel <= ~(4'b0001 << r_idx);
            r_seg <= {~r_dp[r_idx], w_seg_nxt};
         end else begin
            r_sel <= 4'b1111;
            r_seg <= 8'hFF;
         end
      end
   end

   assign bus.o_sel   = r_sel;
   assign bus.o_digit = r_seg;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;

   localparam logic [7:0] BASE = 8'hD0;
   localparam int         DIV  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seven_seg_scan_driver_if bif ();

   seven_seg_scan_driver #(.BASE_ADDR(BASE), .REFRESH_DIV(DIV)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bif.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: architectural register contents plus an edge count since reset.
   logic [3:0] m_dig [4];
   logic       m_en;
   logic [3:0] m_dp;
   int         m_edges;
   int         last_idx;
   logic [7:0] seg7 [16];

   typedef struct {
      logic [3:0] val;
      logic [7:0] seg;
   } dec_vec_t;
   dec_vec_t vec [16];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
      m_en    = 1'b1;
      m_dp    = 4'h0;
      m_edges = 0;
   endtask

   function automatic logic [7:0] model_digit(input int i);
      logic blank;
      logic [6:0] seg;
      blank = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (i > 0) begin
         blank = 1'b1;
         for (int j = i; j < 4; j++) if (m_dig[j] != 4'h0) blank = 1'b0;
      end
`endif
      seg = blank ? 7'h7F : seg7[m_dig[i]][6:0];
      return {~m_dp[i], seg};
   endfunction

   // Called at a negedge: drive inputs, take one rising edge, check outputs at the next negedge.
   task automatic step(input logic we, input logic [7:0] a, input logic [7:0] d);
      logic [7:0] exp_sel, exp_dig;
      int off;
      bif.i_bus_we   = we;
      bif.i_bus_addr = a;
      bif.i_bus_data = d;
      @(posedge clk);
      m_edges++;
      last_idx = ((m_edges - 1) / DIV) % 4;
      if (m_en) begin
         exp_sel = {4'h0, 4'hF & ~(4'(1) << last_idx)};
         exp_dig = model_digit(last_idx);
      end else begin
         exp_sel = 8'h0F;
         exp_dig = 8'hFF;
      end
      off = int'(8'(a - BASE));
      if (we && off < 4) m_dig[off] = d[3:0];
      if (we && off == 4) begin
         m_en = d[0];
         m_dp = d[7:4];
      end
      @(negedge clk);
      chk("sel", {4'h0, bif.o_sel}, exp_sel);
      chk("digit", bif.o_digit, exp_dig);
   endtask

   // Idle until the given digit slot is displayed, then compare DIGIT to a constant.
   task automatic expect_slot(input int idx, input logic [7:0] exp);
      bit found = 0;
      for (int n = 0; n < 4 * DIV + 1 && !found; n++) begin
         step(1'b0, 8'h00, 8'h00);
         if (last_idx == idx) begin
            found = 1;
            chk($sformatf("slot%0d", idx), bif.o_digit, exp);
         end
      end
      if (!found) begin
         n_checks++;
         n_errors++;
         $display("FAIL slot%0d timeout: got none expected %h", idx, exp);
      end
   endtask

   // Reset pulse placed between edges, outputs checked while it is high.
   task automatic pulse_reset();
      bif.i_bus_we = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_sel", {4'h0, bif.o_sel}, 8'h0F);
      chk("rst_digit", bif.o_digit, 8'hFF);
      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] a, d;
      int r;
      seg7 = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      vec = '{'{4'h0, 8'hC0}, '{4'h1, 8'hF9}, '{4'h2, 8'hA4}, '{4'h3, 8'hB0},
              '{4'h4, 8'h99}, '{4'h5, 8'h92}, '{4'h6, 8'h82}, '{4'h7, 8'hF8},
              '{4'h8, 8'h80}, '{4'h9, 8'h90}, '{4'hA, 8'h88}, '{4'hB, 8'h83},
              '{4'hC, 8'hC6}, '{4'hD, 8'hA1}, '{4'hE, 8'h86}, '{4'hF, 8'h8E}};
      bif.i_bus_we   = 1'b0;
      bif.i_bus_addr = 8'h00;
      bif.i_bus_data = 8'h00;
      model_reset();
      last_idx = 0;

      // Held in reset across an edge, then released mid-cycle.
      @(posedge clk);
      #1;
      chk("reset_sel", {4'h0, bif.o_sel}, 8'h0F);
      chk("reset_digit", bif.o_digit, 8'hFF);
      #2 rst = 1'b0;
      @(negedge clk);

      // Idle frame: first edge shows digit 0, each slot DIV cycles.
      for (int i = 0; i < 4 * DIV + 2; i++) step(1'b0, 8'h00, 8'h00);

      step(1'b1, BASE + 8'd0, 8'h01);
      step(1'b1, BASE + 8'd1, 8'h02);
      step(1'b1, BASE + 8'd2, 8'h03);
      step(1'b1, BASE + 8'd3, 8'h04);
      expect_slot(0, 8'hF9);
      expect_slot(1, 8'hA4);
      expect_slot(2, 8'hB0);
      expect_slot(3, 8'h99);
      step(1'b1, BASE + 8'd1, 8'hFB);
      expect_slot(1, 8'h83);

      // Decimal points on digits 0 and 2.
      step(1'b1, BASE + 8'd0, 8'h08);
      step(1'b1, BASE + 8'd4, 8'h51);
      expect_slot(0, 8'h00);
      expect_slot(1, 8'h83);
      expect_slot(2, 8'h30);

      // Disable blanks outputs on the next cycle while the scan keeps going.
      step(1'b1, BASE + 8'd4, 8'h00);
      step(1'b0, 8'h00, 8'h00);
      chk("disabled_sel", {4'h0, bif.o_sel}, 8'h0F);
      chk("disabled_digit", bif.o_digit, 8'hFF);

      // Out-of-range and unstrobed writes must not change anything.
      step(1'b1, BASE + 8'd5, 8'hF1);
      step(1'b1, BASE - 8'd1, 8'h01);
      step(1'b0, BASE + 8'd4, 8'h01);
      step(1'b0, BASE + 8'd0, 8'h05);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00);
      step(1'b1, BASE + 8'd4, 8'h01);
      expect_slot(0, 8'h80);
      expect_slot(3, 8'h99);

      // Leading-zero pattern 0,7,0,0 (digits 3..0), then all zero.
      step(1'b1, BASE + 8'd3, 8'h00);
      step(1'b1, BASE + 8'd2, 8'h07);
      step(1'b1, BASE + 8'd1, 8'h00);
      step(1'b1, BASE + 8'd0, 8'h00);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      expect_slot(3, 8'hFF);
`else
      expect_slot(3, 8'hC0);
`endif
      expect_slot(2, 8'hF8);
      expect_slot(1, 8'hC0);
      expect_slot(0, 8'hC0);
      step(1'b1, BASE + 8'd2, 8'h00);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      expect_slot(2, 8'hFF);
      expect_slot(1, 8'hFF);
`else
      expect_slot(2, 8'hC0);
      expect_slot(1, 8'hC0);
`endif
      expect_slot(0, 8'hC0);

      // Full decode table through digit 0 with junk in the upper nibble.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, BASE, {4'($urandom_range(0, 15)), vec[i].val});
         expect_slot(0, vec[i].seg);
      end

      // Mid-frame reset clears registers and restarts at digit 0.
      step(1'b1, BASE + 8'd1, 8'h05);
      step(1'b1, BASE + 8'd4, 8'hF1);
      for (int i = 0; i < DIV + 1; i++) step(1'b0, 8'h00, 8'h00);
      pulse_reset();
      step(1'b0, 8'h00, 8'h00);
      chk("post_rst_sel", {4'h0, bif.o_sel}, 8'h0E);
      chk("post_rst_digit", bif.o_digit, 8'hC0);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      expect_slot(1, 8'hFF);
`else
      expect_slot(1, 8'hC0);
`endif

      // Random traffic concentrated around the register window.
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 9);
         a = (r < 7) ? 8'(BASE + 8'(r) - 8'd1) : 8'($urandom);
         d = 8'($urandom);
         if ($urandom_range(0, 2) == 0) d[3:0] = 4'h0;
         if (a == BASE + 8'd4) d[0] = ($urandom_range(0, 3) != 0);
         step($urandom_range(0, 3) != 0, a, d);
         if ($urandom_range(0, 199) == 0) pulse_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
